// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the Wishbone UART transmitter:
//   - register offsets as decoded from wbs_adr_i[3:2]
//   - bit positions inside the STATUS and CTRL registers
//   - transmitter FSM state type
//   - even-parity helper (only when UART_TX_PARITY_EN is defined)
// Build option: UART_TX_PARITY_EN adds a parity bit between data and stop.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

   // Register map, word index taken from wbs_adr_i[3:2]
   localparam logic [1:0] ADR_DATA   = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_DIV    = 2'd2;
   localparam logic [1:0] ADR_CTRL   = 2'd3;

   // STATUS bit positions; the fill level occupies bits [15:8]
   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_LVL_LSB = 8;

   // CTRL bit positions
   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

   // Transmitter states; PARITY only exists in the parity build
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } tx_state_e;

`ifdef UART_TX_PARITY_EN
   // Even parity: the bit that makes the total count of ones even
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock byte FIFO used as the UART transmit buffer.
// A push and a pop in the same cycle both succeed, also when full.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   write strobe and byte
//   pop, pop_data     read strobe; pop_data shows the head entry (first-word
//                     fall-through) so the consumer samples it in the pop cycle
//   full, empty       status flags
//   level             number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push_s, do_pop_s;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == LW'(0));
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LW'(1'b1);
         2'b01:   level_d = level_q - LW'(1'b1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care while empty, so it is not reset
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
// Transmit-only UART with a Wishbone classic slave register interface.
// Registers (word index wbs_adr_i[3:2]):
//   0 DATA   write-only, pushes wbs_dat_i[7:0] into the TX FIFO (needs sel[0])
//   1 STATUS read-only except: writing bit3=1 clears the sticky OVF flag
//            bit0 FULL, bit1 EMPTY, bit2 BUSY, bit3 OVF, [15:8] fill level
//   2 DIV    bit period minus one, in clock cycles
//   3 CTRL   bit0 EN (start frames), bit1 IRQ_EN
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat Wishbone classic slave inputs
//   wbs_ack_o, wbs_dat_o       single-cycle ack and registered read data
//   tx_o                       serial output, idle high, registered
//   irq_o                      level interrupt: IRQ_EN & EMPTY & ~BUSY
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (11-bit frame);
// without it the frame is start + 8 data + stop (10 bits).
// -----------------------------------------------------------------------------
module wb_uart_tx
   import uart_tx_pkg::*;
#(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RST    = 16'd433
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // Bus interface
   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rdata_s;
   logic        req_s, wr_s;
   logic [1:0]  reg_sel_s;

   // Registers
   logic [15:0] div_q, div_d;
   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic        ovf_q, ovf_d;
   logic        irq_q, irq_d;

   // Transmitter
   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   // FIFO
   logic             push_s, pop_s;
   logic [7:0]       fifo_rdata_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [LVL_W-1:0] fifo_level_s;
   logic [7:0]       lvl8_s;
   logic             busy_s;

   // Address bits outside [3:2], upper byte lanes and upper data are ignored
   logic unused_s;
   assign unused_s = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

   sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push_s),
      .push_data (wbs_dat_i[7:0]),
      .pop       (pop_s),
      .pop_data  (fifo_rdata_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (fifo_level_s)
   );

   // A new request is one not already being acked; writes commit in the ack cycle
   assign req_s     = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign wr_s      = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i;
   assign reg_sel_s = wbs_adr_i[3:2];
   assign busy_s    = (state_q != ST_IDLE);
   assign lvl8_s    = 8'(fifo_level_s);

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign tx_o      = tx_q;
   assign irq_o     = irq_q;

   // Register writes, DATA pushes and the sticky overflow flag
   always_comb begin
      div_d    = div_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      ovf_d    = ovf_q;
      push_s   = 1'b0;
      if (wr_s) begin
         case (reg_sel_s)
            ADR_DATA: begin
               if (wbs_sel_i[0]) begin
                  // A simultaneous pop makes room, so only a true overflow drops
                  if (fifo_full_s && !pop_s) begin
                     ovf_d = 1'b1;
                  end else begin
                     push_s = 1'b1;
                  end
               end else begin
                  push_s = 1'b0;
               end
            end
            ADR_STATUS: begin
               if (wbs_sel_i[0] && wbs_dat_i[STAT_OVF]) begin
                  ovf_d = 1'b0;
               end else begin
                  ovf_d = ovf_q;
               end
            end
            ADR_DIV: begin
               if (wbs_sel_i[0]) begin
                  div_d[7:0] = wbs_dat_i[7:0];
               end else begin
                  div_d[7:0] = div_q[7:0];
               end
               if (wbs_sel_i[1]) begin
                  div_d[15:8] = wbs_dat_i[15:8];
               end else begin
                  div_d[15:8] = div_q[15:8];
               end
            end
            ADR_CTRL: begin
               if (wbs_sel_i[0]) begin
                  en_d     = wbs_dat_i[CTRL_EN];
                  irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
               end else begin
                  en_d     = en_q;
                  irq_en_d = irq_en_q;
               end
            end
            default: begin
               push_s = 1'b0;
            end
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Read mux and bus handshake; read data is captured so it is stable in the ack cycle
   always_comb begin
      rdata_s = 32'd0;
      case (reg_sel_s)
         ADR_STATUS: begin
            rdata_s[STAT_FULL]                  = fifo_full_s;
            rdata_s[STAT_EMPTY]                 = fifo_empty_s;
            rdata_s[STAT_BUSY]                  = busy_s;
            rdata_s[STAT_OVF]                   = ovf_q;
            rdata_s[STAT_LVL_LSB +: 8]          = lvl8_s;
         end
         ADR_DIV: begin
            rdata_s[15:0] = div_q;
         end
         ADR_CTRL: begin
            rdata_s[CTRL_EN]     = en_q;
            rdata_s[CTRL_IRQ_EN] = irq_en_q;
         end
         default: begin
            rdata_s = 32'd0;
         end
      endcase
      ack_d = req_s;
      if (req_s && !wbs_we_i) begin
         dat_d = rdata_s;
      end else begin
         dat_d = 32'd0;
      end
      irq_d = irq_en_q & fifo_empty_s & ~busy_s;
   end

   // Transmitter FSM and bit timer; tx_d is derived from the next state so
   // the registered line changes together with the state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop_s   = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            // EN is only looked at here, so clearing it lets a frame finish
            if (en_q && !fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_rdata_s;
               cnt_d   = div_q;
               state_d = ST_START;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_START: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_DATA;
               cnt_d   = div_q;
               bit_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d = div_q;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_STOP;
               cnt_d   = div_q;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = even_parity(shift_d);
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // All state registers; reset abandons any frame in flight
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= 32'd0;
         div_q    <= DIV_RST;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         tx_q     <= 1'b1;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         div_q    <= div_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_tx
// Self-checking bench for wb_uart_tx. The expected serial line is computed
// from a queue of transmitted bytes: each frame is start(0), 8 data bits LSB
// first, [even parity], stop(1), every bit DIV+1 cycles, with one idle cycle
// between consecutive frames.
// -----------------------------------------------------------------------------
module tb_wb_uart_tx;

   localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        ack, tx, irq;
   logic [31:0] rdat;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   logic [7:0] exp_q[$];

   wb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RST(16'd433)) dut (
      .wb_clk_i (clk),  .wb_rst_i (rst),
      .wbs_cyc_i(cyc),  .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel),  .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack),  .wbs_dat_o(rdat),
      .tx_o     (tx),   .irq_o    (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, required finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (FRAME_BITS == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   // Expected tx at cycle offset 'off' from the first start bit of exp_q[0]
   function automatic logic exp_tx(input int off, input int div);
      int bl, fl, k, r;
      bl = div + 1;
      fl = FRAME_BITS * bl;
      if (off < 0) return 1'b1;
      k = off / (fl + 1);
      r = off % (fl + 1);
      if (k >= exp_q.size()) return 1'b1;
      if (r == fl) return 1'b1;
      return frame_bit(exp_q[k], r / bl);
   endfunction

   // ---------------- bus transactions ----------------
   task automatic wb_cycle(input logic w, input logic [1:0] ridx, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int ack_c);
      bit got;
      int req_c;
      logic [31:0] r;
      got = 1'b0;
      rd = 32'd0;
      ack_c = -1;
      r = $urandom();
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
      adr = {r[31:4], ridx, r[1:0]};
      req_c = cyc_n;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            got = 1'b1; ack_c = cyc_n; rd = rdat;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_ack_timeout: ack=0 after 8 cycles, required 1");
      end else if (ack_c != req_c + 1) begin
         errors++;
         $display("FAIL wb_ack_latency: ack after %0d cycles, required 1", ack_c - req_c);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL wb_ack_single: ack=%b in cycle after ack, required 0", ack);
      end
   endtask

   task automatic wb_write(input logic [1:0] ridx, input logic [31:0] d, input logic [3:0] s,
                           output int ack_c);
      logic [31:0] rd;
      wb_cycle(1'b1, ridx, d, s, rd, ack_c);
   endtask

   task automatic wb_read(input logic [1:0] ridx, output logic [31:0] rd);
      int ack_c;
      wb_cycle(1'b0, ridx, 32'd0, 4'hF, rd, ack_c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q = {};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || ack !== 1'b0 || irq !== 1'b0 || rdat !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b ack=%b irq=%b dat=%h, required 1 0 0 0", tx, ack, irq, rdat);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wb_read(2'd2, rd);
      checks++; if (rd !== 32'h0000_01B1) begin errors++; $display("FAIL reset_div: %h required 000001b1", rd); end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: %h required 00000002", rd); end
      wb_read(2'd3, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: %h required 00000000", rd); end
      wb_read(2'd0, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL read_data_reg: %h required 00000000", rd); end
   endtask

   task automatic test_frame_55();
      int a, start;
      logic e;
      logic [31:0] rd;
      do_reset();
      wb_write(2'd2, 32'd3, 4'hF, a);
      wb_write(2'd3, 32'd1, 4'hF, a);
      exp_q = {8'h55};
      wb_write(2'd0, 32'h0000_0055, 4'h1, a);
      start = a + 2;
      for (int i = 0; i < FRAME_BITS * 4 + 6; i++) begin
         e = exp_tx(cyc_n - start, 3);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL frame55_tx: offset %0d tx=%b required %b", cyc_n - start, tx, e); end
         @(posedge clk); #1;
      end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL frame55_status: %h required 00000002", rd); end
   endtask

   task automatic test_random_frames();
      int a, start, div;
      logic e;
      logic [7:0] b;
      for (int n = 0; n < 4; n++) begin
         div = $urandom_range(0, 4);
         b = 8'($urandom());
         wb_write(2'd2, 32'(div), 4'h3, a);
         exp_q = {b};
         wb_write(2'd0, {24'($urandom()), b}, 4'h1, a);
         start = a + 2;
         for (int i = 0; i < FRAME_BITS * (div + 1) + 4; i++) begin
            e = exp_tx(cyc_n - start, div);
            checks++;
            if (tx !== e) begin errors++; $display("FAIL random_tx: byte %h div %0d offset %0d tx=%b required %b", b, div, cyc_n - start, tx, e); end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      int a, start, div;
      logic e;
      logic [7:0] b;
      logic [31:0] rd;
      do_reset();
      div = $urandom_range(0, 2);
      wb_write(2'd2, 32'(div), 4'hF, a);
      for (int n = 0; n < 3; n++) begin
         b = 8'($urandom());
         exp_q.push_back(b);
         wb_write(2'd0, {24'd0, b}, 4'h1, a);
      end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0300) begin errors++; $display("FAIL b2b_level: %h required 00000300", rd); end
      wb_write(2'd3, 32'd1, 4'h1, a);
      start = a + 2;
      for (int i = 0; i < 3 * (FRAME_BITS * (div + 1) + 1) + 4; i++) begin
         e = exp_tx(cyc_n - start, div);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL b2b_tx: offset %0d tx=%b required %b", cyc_n - start, tx, e); end
         @(posedge clk); #1;
      end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL b2b_status_end: %h required 00000002", rd); end
   endtask

   task automatic test_overflow();
      int a, start;
      logic e;
      logic [7:0] b;
      logic [31:0] rd;
      do_reset();
      wb_write(2'd2, 32'd0, 4'hF, a);
      wb_write(2'd0, 32'h0000_00A5, 4'hE, a);
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL data_no_sel0: %h required 00000002", rd); end
      for (int n = 0; n < DEPTH + 1; n++) begin
         b = 8'($urandom());
         if (n < DEPTH) exp_q.push_back(b);
         wb_write(2'd0, {24'd0, b}, 4'h1, a);
      end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_1009) begin errors++; $display("FAIL ovf_status: %h required 00001009", rd); end
      wb_write(2'd1, 32'h0000_0008, 4'h1, a);
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_1001) begin errors++; $display("FAIL ovf_clear: %h required 00001001", rd); end
      wb_write(2'd3, 32'd1, 4'h1, a);
      start = a + 2;
      for (int i = 0; i < DEPTH * (FRAME_BITS + 1) + 20; i++) begin
         e = exp_tx(cyc_n - start, 0);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL drain_tx: offset %0d tx=%b required %b", cyc_n - start, tx, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq();
      int a, start, f, off;
      logic e;
      do_reset();
      wb_write(2'd2, 32'd1, 4'hF, a);
      wb_write(2'd3, 32'd1, 4'h1, a);
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: irq=%b required 0", irq); end
      wb_write(2'd3, 32'd3, 4'h1, a);
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_empty: irq=%b required 1", irq); end
      exp_q = {8'($urandom())};
      wb_write(2'd0, {24'd0, exp_q[0]}, 4'h1, a);
      start = a + 2;
      f = FRAME_BITS * 2;
      for (int i = 0; i < f + 5; i++) begin
         off = cyc_n - start;
         e = (off < 0) || (off >= f + 1);
         checks++;
         if (irq !== e) begin errors++; $display("FAIL irq_frame: offset %0d irq=%b required %b", off, irq, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_en_clear();
      int a, start;
      logic e;
      logic [7:0] b0, b1;
      logic [31:0] rd;
      do_reset();
      wb_write(2'd2, 32'd3, 4'hF, a);
      b0 = 8'($urandom());
      b1 = 8'($urandom());
      wb_write(2'd0, {24'd0, b0}, 4'h1, a);
      wb_write(2'd0, {24'd0, b1}, 4'h1, a);
      exp_q = {b0};
      wb_write(2'd3, 32'd1, 4'h1, a);
      start = a + 2;
      wb_write(2'd3, 32'd0, 4'h1, a);
      while (cyc_n - start < FRAME_BITS * 4 + 40) begin
         e = exp_tx(cyc_n - start, 3);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL en_clear_tx: offset %0d tx=%b required %b", cyc_n - start, tx, e); end
         @(posedge clk); #1;
      end
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL en_clear_status: %h required 00000100", rd); end
   endtask

   task automatic test_reset_midframe();
      int a, start;
      logic [31:0] rd;
      logic [7:0] b;
      do_reset();
      wb_write(2'd2, 32'd3, 4'hF, a);
      wb_write(2'd3, 32'd1, 4'h1, a);
      b = 8'($urandom()) & 8'hF7;
      exp_q = {b};
      wb_write(2'd0, {24'd0, b}, 4'h1, a);
      start = a + 2;
      for (int i = 0; i < 40 && (cyc_n - start) < 17; i++) begin
         @(posedge clk); #1;
      end
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3: tx=%b required 0", tx); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: tx=%b required 1", tx); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wb_read(2'd1, rd);
      checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL midframe_status: %h required 00000002", rd); end
      wb_read(2'd2, rd);
      checks++; if (rd !== 32'h0000_01B1) begin errors++; $display("FAIL midframe_div: %h required 000001b1", rd); end
      for (int i = 0; i < 60; i++) begin
         checks++;
         if (tx !== 1'b1) begin errors++; $display("FAIL midframe_residual: cycle %0d tx=%b required 1", i, tx); end
         @(posedge clk); #1;
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int a, start;
      logic e;
      do_reset();
      wb_write(2'd2, 32'd3, 4'hF, a);
      wb_write(2'd3, 32'd1, 4'h1, a);
      exp_q = {8'h07};
      wb_write(2'd0, 32'h0000_0007, 4'h1, a);
      start = a + 2;
      for (int i = 0; i < 44 + 6; i++) begin
         e = exp_tx(cyc_n - start, 3);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL parity_tx: offset %0d tx=%b required %b", cyc_n - start, tx, e); end
         @(posedge clk); #1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_55();
      test_random_frames();
      test_back_to_back();
      test_overflow();
      test_irq();
      test_en_clear();
      test_reset_midframe();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: TX FIFO entries; the value SHALL be a power of 2, minimum 2.
REQ-002 Parameter DIV_RST, default 16'd433: reset value of DIV, giving 115200 baud at 50 MHz.
REQ-003 wb_clk_i  in  1  sole clock; all logic is on its rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous assert, active-high.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-006 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-007 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-008 tx_o  out  1  serial line, idle high; irq_o  out  1  level interrupt.

Function
REQ-009 Decode SHALL use wbs_adr_i[3:2] only: 0 DATA (write-only), 1 STATUS (read-only), 2 DIV (RW, bits[15:0]), 3 CTRL (RW: bit0 EN, bit1 IRQ_EN).
REQ-010 ack SHALL rise one cycle after cyc&stb&~ack, last exactly one cycle, and never assert on consecutive cycles.
REQ-011 Register writes SHALL take effect in the ack cycle and only for lanes with sel set; a DATA push requires sel[0].
REQ-012 Reads of DATA SHALL return 0; unused bits SHALL read 0; wbs_dat_o is valid in the ack cycle.
REQ-013 STATUS layout: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF, bits[15:8] fill level.
REQ-014 A DATA write while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set OVF (sticky).
REQ-015 OVF SHALL clear only on a STATUS write with wbs_dat_i[3]=1; this write is the sole exception to STATUS being read-only.
REQ-016 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; the level is unchanged.
REQ-017 FSM states: IDLE, START, DATA, STOP; PARITY is added per REQ-027.
REQ-018 IDLE->START occurs when EN=1 and the FIFO is not empty; the byte is popped in the same cycle.
REQ-019 START->DATA->STOP->IDLE transitions are driven by the bit timer; DATA sends 8 bits, LSB first.
REQ-020 Each bit SHALL last DIV+1 cycles; the bit counter loads DIV at each bit start and a DIV change applies from the next bit boundary.
REQ-021 tx_o SHALL be 0 in START, the data bit in DATA, and 1 in STOP and IDLE; tx_o SHALL be registered.
REQ-022 First-frame latency: tx_o falls exactly 2 cycles after the ack cycle of a DATA write into an empty FIFO with EN=1.
REQ-023 Clearing EN mid-frame SHALL let the current frame complete; no further pops occur.
REQ-024 irq_o = IRQ_EN & EMPTY & ~BUSY, registered.

Reset
REQ-025 On reset, asynchronously: tx_o=1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, FSM=IDLE, FIFO empty, OVF=0, DIV=DIV_RST, CTRL=0. A frame in flight when reset asserts SHALL be abandoned.

Configuration
REQ-026 Macro UART_TX_PARITY_EN SHALL gate the parity feature.
REQ-027 With UART_TX_PARITY_EN defined: a PARITY state sits between DATA and STOP and sends even parity (XOR of the 8 data bits) for one bit time; the frame is 11 bits.
REQ-028 Without UART_TX_PARITY_EN: no PARITY state or logic exists; the frame is 10 bits.

Structure
REQ-029 Package uart_tx_pkg SHALL hold the register offset constants, STATUS/CTRL bit indices, and the FSM state typedef.
REQ-030 Sub-module sync_fifo (8-bit wide, FIFO_DEPTH deep, push/pop/full/empty/level) SHALL hold the FIFO storage.

Verification
REQ-031 Reset, then read DIV -> 0x000001B1; read STATUS -> EMPTY=1, all other bits 0; tx_o=1.
REQ-032 Write DIV=3, CTRL=1, DATA=0x55 -> tx_o low at ack+2; bits 1,0,1,0,1,0,1,0 follow, 4 cycles each; stop high; frame totals 40 cycles.
REQ-033 With EN=0, write 17 bytes -> STATUS FULL=1, level=16, OVF=1; write STATUS 0x8 -> OVF=0.
REQ-034 CTRL=3, send one byte -> irq_o=0 while BUSY and 1 the cycle after the FSM returns to IDLE with the FIFO empty.
REQ-035 Assert reset during bit 3 of a frame -> tx_o=1 immediately, FIFO empty, and no residual frame after reset release.
REQ-036 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame totals 44 cycles at DIV=3.
